// File: rtl/core_types_pkg.sv
// Core-side types: instruction cache geometry, frame layout and fill FSM states.
package core_types_pkg;

  localparam int ICACHE_NUM_SETS    = 16;
  localparam int ICACHE_IDX_W       = $clog2(ICACHE_NUM_SETS);
  localparam int ICACHE_BLOCK_WORDS = 2;
  localparam int ICACHE_TAG_W       = 32 - 3 - ICACHE_IDX_W;

  typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;
  typedef logic [ICACHE_IDX_W-1:0] icache_idx_t;

  typedef struct packed {
    logic                                valid;
    icache_tag_t                         tag;
    logic [ICACHE_BLOCK_WORDS-1:0][31:0] data;
  } icache_frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2
  } icache_state_t;

endpackage

// File: rtl/mem_types_pkg.sv
// Memory-system types shared by the caches and the RAM arbiter.
package mem_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/icache_frames.sv
// Direct-mapped frame array: one combinational read port, one synchronous write port.
// Valid bits clear on reset or clear-all (clear beats a same-cycle write); tag/data are never reset.
module icache_frames
  import core_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  input  logic          clear,
  input  icache_idx_t   rd_idx,
  output icache_frame_t rd_frame,
  input  logic          wr_en,
  input  icache_idx_t   wr_idx,
  input  icache_frame_t wr_frame
);

  logic [ICACHE_NUM_SETS-1:0]          valid;
  icache_tag_t                         tags [ICACHE_NUM_SETS];
  logic [ICACHE_BLOCK_WORDS-1:0][31:0] data [ICACHE_NUM_SETS];

  always_ff @(posedge CLK) begin
    if (nRST || clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= wr_frame.valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_frame.tag;
      data[wr_idx] <= wr_frame.data;
    end
  end

  always_comb begin
    rd_frame       = '0;
    rd_frame.valid = valid[rd_idx];
    rd_frame.tag   = tags[rd_idx];
    rd_frame.data  = data[rd_idx];
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only i$: hits return in the request cycle, misses fill a 2-word block (2 RAM accesses + 1 cycle).
// Fills stall until mem_state==ACCESS with mem_REN held; ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_dm
  import core_types_pkg::*;
  import mem_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        icache_REN,
  input  logic [31:0] icache_addr,
  output logic        icache_hit,
  output logic [31:0] icache_load,
  input  logic        flush,
  output logic        mem_REN,
  output logic [31:0] mem_addr,
  input  ramstate_t   mem_state,
  input  logic [31:0] mem_load
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  icache_state_t state;
  icache_tag_t   req_tag, miss_tag;
  icache_idx_t   req_idx, miss_idx;
  logic [31:0]   fill_word0;
  icache_frame_t rd_frame, wr_frame;
  logic          tag_match, lookup, miss, wr_en;
  logic          unused_byte_off;

  assign req_tag         = icache_addr[31:3+ICACHE_IDX_W];
  assign req_idx         = icache_addr[2+ICACHE_IDX_W:3];
  assign unused_byte_off = ^icache_addr[1:0];

  assign tag_match   = rd_frame.valid && (rd_frame.tag == req_tag);
  // Lookups only happen in IDLE; reset and flush both mask the hit.
  assign lookup      = !nRST && !flush && (state == IDLE) && icache_REN;
  assign icache_hit  = lookup && tag_match;
  assign miss        = lookup && !tag_match;
  assign icache_load = icache_hit ? rd_frame.data[icache_addr[2]] : 32'd0;

  assign mem_REN  = !nRST && ((state == FILL0) || (state == FILL1));
  assign mem_addr = mem_REN ? {miss_tag, miss_idx, (state == FILL1), 2'b00} : 32'd0;

  assign wr_en = !nRST && !flush && (state == FILL1) && (mem_state == ACCESS);

  always_comb begin
    wr_frame         = '0;
    wr_frame.valid   = 1'b1;
    wr_frame.tag     = miss_tag;
    wr_frame.data[0] = fill_word0;
    wr_frame.data[1] = mem_load;
  end

  always_ff @(posedge CLK) begin
    if (nRST || flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (miss) state <= FILL0;
        FILL0:   if (mem_state == ACCESS) state <= FILL1;
        FILL1:   if (mem_state == ACCESS) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Miss address and first fill word carry no reset; they are only read in FILL states.
  always_ff @(posedge CLK) begin
    if (miss) begin
      miss_tag <= req_tag;
      miss_idx <= req_idx;
    end
    if ((state == FILL0) && (mem_state == ACCESS)) begin
      fill_word0 <= mem_load;
    end
  end

  icache_frames u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .clear    (flush),
    .rd_idx   (req_idx),
    .rd_frame (rd_frame),
    .wr_en    (wr_en),
    .wr_idx   (miss_idx),
    .wr_frame (wr_frame)
  );

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (nRST) begin
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
    end else begin
      if (icache_hit && (stat_hits != 32'hFFFF_FFFF)) stat_hits <= stat_hits + 32'd1;
      if (miss && (stat_misses != 32'hFFFF_FFFF)) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: RAM responder answers each request with one BUSY cycle then ACCESS.
// RAM word at byte address a is {16'hCAFE, a[15:0]}.
module tb_icache_dm;
  import mem_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        icache_REN = 1'b0;
  logic [31:0] icache_addr = 32'd0;
  logic        icache_hit;
  logic [31:0] icache_load;
  logic        flush = 1'b0;
  logic        mem_REN;
  logic [31:0] mem_addr;
  ramstate_t   mem_state = FREE;
  logic [31:0] mem_load = 32'd0;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int          n_cmp = 0;
  int          n_fail = 0;
  logic        ram_auto = 1'b1;
  logic        busy_done = 1'b0;
  logic [31:0] acc[$];

  icache_dm dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .icache_REN  (icache_REN),
    .icache_addr (icache_addr),
    .icache_hit  (icache_hit),
    .icache_load (icache_load),
    .flush       (flush),
    .mem_REN     (mem_REN),
    .mem_addr    (mem_addr),
    .mem_state   (mem_state),
    .mem_load    (mem_load)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {16'hCAFE, a[15:0]};
  endfunction

  always begin
    @(posedge CLK);
    #2;
    if (ram_auto) begin
      if (!mem_REN) begin
        mem_state = FREE;
        busy_done = 1'b0;
      end else if (!busy_done) begin
        mem_state = BUSY;
        busy_done = 1'b1;
      end else begin
        mem_state = ACCESS;
        mem_load  = ram_word(mem_addr);
        acc.push_back(mem_addr);
        busy_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    tick();
    nRST = 1'b1; flush = 1'b0; icache_REN = 1'b0; icache_addr = 32'd0; ram_auto = 1'b1;
    tick();
    tick();
    nRST = 1'b0;
    acc.delete();
    @(negedge CLK);
  endtask

  // Steps whole cycles until icache_hit is seen at a negedge; cycles=-1 on timeout.
  task automatic run_fill(input int max, output int cycles, output int bad);
    cycles = -1;
    bad = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (icache_hit && mem_REN) bad++;
      if (icache_hit) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    nRST = 1'b1; flush = 1'b1; icache_REN = 1'b1; icache_addr = 32'h40;
    tick();
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", icache_hit); end
    n_cmp++; if (icache_load !== 32'd0) begin n_fail++; $display("FAIL rst_load: got %h want 0", icache_load); end
    n_cmp++; if (mem_REN !== 1'b0) begin n_fail++; $display("FAIL rst_mem_REN: got %b want 0", mem_REN); end
    n_cmp++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
`ifdef ICACHE_STATS_EN
    n_cmp++; if (stat_hits !== 32'd0) begin n_fail++; $display("FAIL rst_stat_hits: got %0d want 0", stat_hits); end
    n_cmp++; if (stat_misses !== 32'd0) begin n_fail++; $display("FAIL rst_stat_misses: got %0d want 0", stat_misses); end
`endif
    tick();
    nRST = 1'b0; flush = 1'b0;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL rst_cold_valid: got %b want 0", icache_hit); end
  endtask

  task automatic test_cold_miss();
    int c, b;
    do_reset();
    tick();
    icache_REN = 1'b1; icache_addr = 32'h40;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL cold_req_hit: got %b want 0", icache_hit); end
    n_cmp++; if (mem_REN !== 1'b0) begin n_fail++; $display("FAIL cold_idle_mem_REN: got %b want 0", mem_REN); end
    run_fill(20, c, b);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL cold_latency: got %0d want 5", c); end
    n_cmp++; if (b !== 0) begin n_fail++; $display("FAIL cold_hit_in_fill: got %0d want 0", b); end
    n_cmp++; if (icache_load !== 32'hCAFE0040) begin n_fail++; $display("FAIL cold_load: got %h want cafe0040", icache_load); end
    n_cmp++; if (acc.size() !== 2) begin n_fail++; $display("FAIL cold_txn_count: got %0d want 2", acc.size()); end
    n_cmp++; if (acc[0] !== 32'h40) begin n_fail++; $display("FAIL cold_addr0: got %h want 40", acc[0]); end
    n_cmp++; if (acc[1] !== 32'h44) begin n_fail++; $display("FAIL cold_addr1: got %h want 44", acc[1]); end
  endtask

  task automatic test_spatial_hit();
    tick();
    icache_addr = 32'h44;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b1) begin n_fail++; $display("FAIL spatial_hit: got %b want 1", icache_hit); end
    n_cmp++; if (icache_load !== 32'hCAFE0044) begin n_fail++; $display("FAIL spatial_load: got %h want cafe0044", icache_load); end
    n_cmp++; if (mem_REN !== 1'b0) begin n_fail++; $display("FAIL spatial_mem_REN: got %b want 0", mem_REN); end
    tick();
    icache_REN = 1'b0;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL noren_hit: got %b want 0", icache_hit); end
    n_cmp++; if (icache_load !== 32'd0) begin n_fail++; $display("FAIL noren_load: got %h want 0", icache_load); end
  endtask

  task automatic test_conflict();
    int c, b;
    tick();
    acc.delete();
    icache_REN = 1'b1; icache_addr = 32'hC0;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL conflict_c0_hit: got %b want 0", icache_hit); end
    run_fill(20, c, b);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL conflict_c0_latency: got %0d want 5", c); end
    n_cmp++; if (icache_load !== 32'hCAFE00C0) begin n_fail++; $display("FAIL conflict_c0_load: got %h want cafe00c0", icache_load); end
    n_cmp++; if (acc[0] !== 32'hC0) begin n_fail++; $display("FAIL conflict_c0_addr: got %h want c0", acc[0]); end
    tick();
    acc.delete();
    icache_addr = 32'h40;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL conflict_40_evicted: got %b want 0", icache_hit); end
    run_fill(20, c, b);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL conflict_40_latency: got %0d want 5", c); end
    n_cmp++; if (icache_load !== 32'hCAFE0040) begin n_fail++; $display("FAIL conflict_40_load: got %h want cafe0040", icache_load); end
    n_cmp++; if (acc[0] !== 32'h40) begin n_fail++; $display("FAIL conflict_40_addr: got %h want 40", acc[0]); end
  endtask

  task automatic test_addr_change();
    int c, b;
    do_reset();
    tick();
    icache_REN = 1'b1; icache_addr = 32'h40;
    @(negedge CLK);
    tick();
    icache_addr = 32'h100;
    @(negedge CLK);
    n_cmp++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL chg_latched_addr: got %h want 40", mem_addr); end
    run_fill(40, c, b);
    n_cmp++; if (c !== 9) begin n_fail++; $display("FAIL chg_latency: got %0d want 9", c); end
    n_cmp++; if (b !== 0) begin n_fail++; $display("FAIL chg_hit_in_fill: got %0d want 0", b); end
    n_cmp++; if (icache_load !== 32'hCAFE0100) begin n_fail++; $display("FAIL chg_load: got %h want cafe0100", icache_load); end
    n_cmp++; if (acc.size() !== 4) begin n_fail++; $display("FAIL chg_txn_count: got %0d want 4", acc.size()); end
    n_cmp++; if (acc[1] !== 32'h44) begin n_fail++; $display("FAIL chg_addr1: got %h want 44", acc[1]); end
    n_cmp++; if (acc[2] !== 32'h100) begin n_fail++; $display("FAIL chg_addr2: got %h want 100", acc[2]); end
    n_cmp++; if (acc[3] !== 32'h104) begin n_fail++; $display("FAIL chg_addr3: got %h want 104", acc[3]); end
    tick();
    icache_addr = 32'h40;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b1) begin n_fail++; $display("FAIL chg_40_filled: got %b want 1", icache_hit); end
    // Switch to a cached address during a fill: it must not hit until IDLE.
    tick();
    acc.delete();
    icache_addr = 32'hC0;
    @(negedge CLK);
    tick();
    icache_addr = 32'h100;
    run_fill(20, c, b);
    n_cmp++; if (c !== 4) begin n_fail++; $display("FAIL nohum_latency: got %0d want 4", c); end
    n_cmp++; if (b !== 0) begin n_fail++; $display("FAIL nohum_hit_in_fill: got %0d want 0", b); end
    n_cmp++; if (acc.size() !== 2) begin n_fail++; $display("FAIL nohum_txn_count: got %0d want 2", acc.size()); end
    n_cmp++; if (icache_load !== 32'hCAFE0100) begin n_fail++; $display("FAIL nohum_load: got %h want cafe0100", icache_load); end
  endtask

  task automatic test_error_hold();
    ramstate_t hold_st[3] = '{ERROR, BUSY, FREE};
    tick();
    ram_auto = 1'b0; mem_state = FREE; icache_REN = 1'b1; icache_addr = 32'h80;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL err_req_hit: got %b want 0", icache_hit); end
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_state = hold_st[i]; mem_load = 32'hDEADBEEF;
      @(negedge CLK);
      n_cmp++; if (mem_REN !== 1'b1) begin n_fail++; $display("FAIL err_hold_ren%0d: got %b want 1", i, mem_REN); end
      n_cmp++; if (mem_addr !== 32'h80) begin n_fail++; $display("FAIL err_hold_addr%0d: got %h want 80", i, mem_addr); end
    end
    tick();
    mem_state = ACCESS; mem_load = 32'h1111_1111;
    @(negedge CLK);
    tick();
    mem_state = ERROR; mem_load = 32'hDEADBEEF;
    @(negedge CLK);
    n_cmp++; if (mem_addr !== 32'h84) begin n_fail++; $display("FAIL err_fill1_addr: got %h want 84", mem_addr); end
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL err_fill1_hit: got %b want 0", icache_hit); end
    tick();
    mem_state = ACCESS; mem_load = 32'h2222_2222;
    @(negedge CLK);
    tick();
    mem_state = FREE;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b1) begin n_fail++; $display("FAIL err_post_hit: got %b want 1", icache_hit); end
    n_cmp++; if (icache_load !== 32'h1111_1111) begin n_fail++; $display("FAIL err_word0: got %h want 11111111", icache_load); end
    tick();
    icache_addr = 32'h84;
    @(negedge CLK);
    n_cmp++; if (icache_load !== 32'h2222_2222) begin n_fail++; $display("FAIL err_word1: got %h want 22222222", icache_load); end
    busy_done = 1'b0; ram_auto = 1'b1;
  endtask

  task automatic test_flush_mid_fill();
    int c, b;
    tick();
    acc.delete();
    icache_REN = 1'b1; icache_addr = 32'h40;
    @(negedge CLK);
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    @(negedge CLK);
    n_cmp++; if (mem_addr !== 32'h44) begin n_fail++; $display("FAIL flush_fill1_addr: got %h want 44", mem_addr); end
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL flush_fill_hit: got %b want 0", icache_hit); end
    tick();
    flush = 1'b0; icache_REN = 1'b0;
    @(negedge CLK);
    n_cmp++; if (mem_REN !== 1'b0) begin n_fail++; $display("FAIL flush_to_idle: got %b want 0", mem_REN); end
    tick();
    acc.delete();
    icache_REN = 1'b1;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL flush_aborted_write: got %b want 0", icache_hit); end
    run_fill(20, c, b);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL flush_refill_latency: got %0d want 5", c); end
    n_cmp++; if (acc[0] !== 32'h40) begin n_fail++; $display("FAIL flush_refill_addr: got %h want 40", acc[0]); end
    tick();
    icache_addr = 32'h84;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL flush_cleared_idx0: got %b want 0", icache_hit); end
    run_fill(20, c, b);
    n_cmp++; if (icache_load !== 32'hCAFE0084) begin n_fail++; $display("FAIL flush_84_load: got %h want cafe0084", icache_load); end
  endtask

  task automatic test_flush_hit();
    int c, b;
    tick();
    icache_addr = 32'h40; flush = 1'b1;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL flushcyc_hit: got %b want 0", icache_hit); end
    n_cmp++; if (icache_load !== 32'd0) begin n_fail++; $display("FAIL flushcyc_load: got %h want 0", icache_load); end
    tick();
    flush = 1'b0;
    @(negedge CLK);
    n_cmp++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL flushcyc_cleared: got %b want 0", icache_hit); end
    run_fill(20, c, b);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL flushcyc_refill: got %0d want 5", c); end
    tick();
    icache_REN = 1'b0;
  endtask

`ifdef ICACHE_STATS_EN
  task automatic test_stats();
    int c, b;
    do_reset();
    tick();
    icache_REN = 1'b1; icache_addr = 32'h40;
    @(negedge CLK);
    n_cmp++; if (stat_misses !== 32'd0) begin n_fail++; $display("FAIL stats_miss_before: got %0d want 0", stat_misses); end
    run_fill(20, c, b);
    n_cmp++; if (c !== 5) begin n_fail++; $display("FAIL stats_fill: got %0d want 5", c); end
    tick();
    @(negedge CLK);
    tick();
    icache_addr = 32'h44;
    @(negedge CLK);
    tick();
    icache_REN = 1'b0;
    @(negedge CLK);
    n_cmp++; if (stat_hits !== 32'd3) begin n_fail++; $display("FAIL stats_hits: got %0d want 3", stat_hits); end
    n_cmp++; if (stat_misses !== 32'd1) begin n_fail++; $display("FAIL stats_misses: got %0d want 1", stat_misses); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge CLK);
    n_cmp++; if (stat_hits !== 32'd3) begin n_fail++; $display("FAIL stats_hits_flush: got %0d want 3", stat_hits); end
    n_cmp++; if (stat_misses !== 32'd1) begin n_fail++; $display("FAIL stats_misses_flush: got %0d want 1", stat_misses); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_spatial_hit();
    test_conflict();
    test_addr_change();
    test_error_hold();
    test_flush_mid_fill();
    test_flush_hit();
`ifdef ICACHE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core's i$ port (icache_REN/icache_addr/icache_hit/icache_load) and the system memory arbiter's RAM-side request.
- Hits are returned combinationally in the request cycle. Misses fill a 2-word block from RAM through a small FSM.
- Replaces the "every i$ read goes straight to RAM" path, so the d$ path gets more RAM cycles.

Parameters:
- NUM_SETS, 16, number of frames (power of 2); index width IDX_W = log2(NUM_SETS)
- BLOCK_WORDS, 2, words per block (fixed at 2; not generic)

Ports:
- CLK  in  1  system clock (CPUCLK domain)
- nRST  in  1  synchronous, active-high reset (1 = reset); port name kept for codebase consistency
- icache_REN  in  1  core instruction read request
- icache_addr  in  32  byte address; bits [1:0] ignored
- icache_hit  out  1  icache_load valid this cycle
- icache_load  out  32  instruction word
- flush  in  1  invalidate all frames
- mem_REN  out  1  RAM read request to arbiter
- mem_addr  out  32  RAM byte address
- mem_state  in  ramstate_t  arbiter/RAM status (FREE, BUSY, ACCESS, ERROR)
- mem_load  in  32  RAM read data, valid when mem_state == ACCESS

Behaviour:
- Address split: [1:0] byte offset, [2] word-in-block, [2+IDX_W:3] index, [31:3+IDX_W] tag.
- Storage per frame: valid, tag, data[2]. All valid bits clear on reset; tag and data are not reset.
- FSM states: IDLE, FILL0, FILL1. Reset -> IDLE.
- IDLE:
  - icache_REN with valid and tag match -> icache_hit=1, icache_load = data[addr[2]], same cycle (zero latency).
  - icache_REN and miss -> latch miss tag/index into miss register; next state FILL0. icache_hit=0.
- FILL0:
  - mem_REN=1, mem_addr={miss_tag, miss_idx, 1'b0, 2'b00}.
  - On mem_state==ACCESS: capture mem_load into fill buffer word0 -> FILL1. Otherwise stay.
- FILL1:
  - mem_REN=1, mem_addr={miss_tag, miss_idx, 1'b1, 2'b00}.
  - On ACCESS: write the frame (data0, mem_load, tag) and set valid -> IDLE. Otherwise stay.
- After a fill, the original request hits in the first IDLE cycle. Miss penalty = 2 RAM accesses + 1 cycle.
- icache_hit=0 in FILL0/FILL1, even if the address changed to one that would hit. No hit-under-miss.
- Core withdraws or changes icache_REN/icache_addr mid-fill: the fill completes for the latched address; the new address is evaluated in IDLE.
- mem_state ERROR, BUSY or FREE during a fill: no capture, hold state and address, keep mem_REN=1.
- Outputs at reset: icache_hit=0, icache_load=0, mem_REN=0, mem_addr=0.
- icache_load=0 whenever icache_hit=0.
- mem_REN=0 in IDLE.
- flush:
  - Clears all valid bits at the clock edge and forces FSM to IDLE, aborting any fill (no frame written).
  - icache_hit forced 0 in the flush cycle.
  - flush and reset together: reset dominates; outcome is identical.
- Fill write to a frame already valid with another tag: overwrite, no eviction bookkeeping.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hits (32) and stat_misses (32), both 0 on reset.
  - stat_hits increments each IDLE cycle with icache_hit=1.
  - stat_misses increments on each IDLE->FILL0 transition.
  - Both saturate at 32'hFFFFFFFF; flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- core_types_pkg gets:
  - ICACHE_NUM_SETS constant
  - icache_tag_t, icache_idx_t
  - icache_frame_t (packed struct: valid, tag, data[2])
  - icache_state_t enum (IDLE, FILL0, FILL1)
- ramstate_t comes from mem_types_pkg.
- One natural sub-module, icache_frames: frame array with one combinational read port, one synchronous write port and a synchronous clear-all. FSM and miss register stay in icache_dm.

Test Plan:
- Cold miss: after reset, REN=1, addr=0x0000_0040. Expect:
  - mem_addr=0x40, then 0x44 (ACCESS each after 1 BUSY cycle)
  - icache_hit=1 with load = word at 0x40 on the cycle after FILL1 ACCESS
  - 2 mem_REN transactions total
- Spatial hit: after the cold miss, addr=0x44 -> icache_hit=1 same cycle, load = word at 0x44, mem_REN=0.
- Conflict: fill 0x0040, then read 0x00C0 (same index, tag differs) -> miss and refill; re-read 0x0040 -> miss again.
- Address change mid-fill: switch addr to 0x0100 during FILL0. Expect:
  - fill completes for 0x40/0x44
  - then a miss on 0x100 with mem_addr=0x100
  - no hit asserted during either fill
- Flush mid-fill: flush=1 in FILL1 -> IDLE next cycle, frame 8 invalid; re-read 0x40 -> fresh fill with mem_addr=0x40.
- Stats (ICACHE_STATS_EN defined): cold miss, hit, hit -> stat_misses=1; stat_hits=3 (the post-fill hit cycle counts).
